// File: rtl/phy_muxnto1_sync_if.sv
//==============================================================================
// phy_muxnto1_sync_if : channel bus and select handshake for phy_muxnto1_sync
// Revision: 1.0
//==============================================================================
`default_nettype none

interface phy_muxnto1_sync_if #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 1
) ();
    localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] muxin;
    logic [SEL_W-1:0]        sel_in;
    logic                    sel_valid;
    logic                    sel_ready;
    logic                    sel_done;
    logic                    sel_err;
    logic [SEL_W-1:0]        sel_cur;
    logic                    busy;
    logic [WIDTH-1:0]        muxout;

    modport master (
        output muxin, sel_in, sel_valid,
        input  sel_ready, sel_done, sel_err, sel_cur, busy, muxout
    );

    modport slave (
        input  muxin, sel_in, sel_valid,
        output sel_ready, sel_done, sel_err, sel_cur, busy, muxout
    );
endinterface

`default_nettype wire

// File: rtl/phy_muxnto1_sync.sv
//==============================================================================
// phy_muxnto1_sync : registered N-to-1 mux with glitch-free blanked switching
// Revision: 1.0
//==============================================================================
`default_nettype none

module phy_muxnto1_sync #(
    parameter int               NUM_IN       = 4,
    parameter int               WIDTH        = 1,
    parameter int               BLANK_CYCLES = 2,
    parameter logic [WIDTH-1:0] IDLE_VAL     = '0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    phy_muxnto1_sync_if.slave  bus
);
    localparam int                SEL_W   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;
    localparam int                N_SLOTS = 1 << SEL_W;
    localparam logic [SEL_W:0]    C_NUM   = (SEL_W+1)'(NUM_IN);
    localparam logic [3:0]        C_BLANK = 4'(BLANK_CYCLES);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SEL_W-1:0]   pending_q, pending_d;
    logic [SEL_W-1:0]   sel_cur_q, sel_cur_d;
    logic [WIDTH-1:0]   muxout_q, muxout_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept;
    logic               out_of_range;

    // Unused index slots above NUM_IN read as zero so the lookup is total.
    logic [WIDTH-1:0]   chans [N_SLOTS];

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_chan
        if (i < NUM_IN) begin : g_used
            assign chans[i] = bus.muxin[i*WIDTH +: WIDTH];
        end else begin : g_unused
            assign chans[i] = '0;
        end
    end

    assign accept       = bus.sel_valid && (state_q == ST_RUN);
    assign out_of_range = ({1'b0, bus.sel_in} >= C_NUM);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        sel_cur_d = sel_cur_q;
        muxout_d  = muxout_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_RUN: begin
                muxout_d = chans[sel_cur_q];
                if (accept) begin
                    if (out_of_range) begin
                        err_d = 1'b1;
                    end else if (bus.sel_in == sel_cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        pending_d = bus.sel_in;
                        muxout_d  = IDLE_VAL;
                        cnt_d     = C_BLANK;
                        state_d   = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                muxout_d = IDLE_VAL;
                cnt_d    = cnt_q - 4'd1;
                // Final blank edge commits the new channel directly, so no
                // mixed old/new word can ever reach muxout.
                if (cnt_q == 4'd1) begin
                    sel_cur_d = pending_q;
                    muxout_d  = chans[pending_q];
                    done_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pending_q <= '0;
            sel_cur_q <= '0;
            muxout_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            sel_cur_q <= sel_cur_d;
            muxout_q  <= muxout_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.sel_ready = (state_q == ST_RUN);
    assign bus.busy      = (state_q == ST_BLANK);
    assign bus.sel_done  = done_q;
    assign bus.sel_err   = err_q;
    assign bus.sel_cur   = sel_cur_q;
    assign bus.muxout    = muxout_q;

endmodule

`default_nettype wire

// File: tb/tb_phy_muxnto1_sync.sv
//==============================================================================
// tb_phy_muxnto1_sync : directed self-checking bench for phy_muxnto1_sync
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_phy_muxnto1_sync;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    phy_muxnto1_sync_if #(.NUM_IN(4), .WIDTH(8)) bus4 ();
    phy_muxnto1_sync_if #(.NUM_IN(5), .WIDTH(8)) bus5 ();

    phy_muxnto1_sync #(
        .NUM_IN(4), .WIDTH(8), .BLANK_CYCLES(2), .IDLE_VAL(8'h00)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    phy_muxnto1_sync #(
        .NUM_IN(5), .WIDTH(8), .BLANK_CYCLES(2), .IDLE_VAL(8'h00)
    ) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        bus4.muxin = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus4.sel_in = '0;
        bus4.sel_valid = 1'b0;
        bus5.muxin = {8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus5.sel_in = '0;
        bus5.sel_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_muxout",  64'(bus4.muxout),    64'h00);
        chk("rst_sel_cur", 64'(bus4.sel_cur),   64'd0);
        chk("rst_ready",   64'(bus4.sel_ready), 64'd1);
        chk("rst_busy",    64'(bus4.busy),      64'd0);
        chk("rst_done",    64'(bus4.sel_done),  64'd0);
        chk("rst_err",     64'(bus4.sel_err),   64'd0);

        reset = 1'b0;
        tick();
        chk("post_rst_muxout", 64'(bus4.muxout), 64'hAA);

        bus4.muxin[7:0] = 8'h5A;
        tick();
        chk("track_ch0", 64'(bus4.muxout), 64'h5A);
        bus4.muxin[7:0] = 8'hAA;
        tick();

        // Switch to channel 2 with two blank cycles
        bus4.sel_valid = 1'b1;
        bus4.sel_in    = 2'd2;
        tick();
        bus4.sel_valid = 1'b0;
        chk("sw2_e0_muxout", 64'(bus4.muxout),    64'h00);
        chk("sw2_e0_busy",   64'(bus4.busy),      64'd1);
        chk("sw2_e0_ready",  64'(bus4.sel_ready), 64'd0);
        chk("sw2_e0_cur",    64'(bus4.sel_cur),   64'd0);
        chk("sw2_e0_done",   64'(bus4.sel_done),  64'd0);
        tick();
        chk("sw2_e1_muxout", 64'(bus4.muxout),    64'h00);
        chk("sw2_e1_busy",   64'(bus4.busy),      64'd1);
        chk("sw2_e1_done",   64'(bus4.sel_done),  64'd0);
        tick();
        chk("sw2_e2_muxout", 64'(bus4.muxout),    64'hCC);
        chk("sw2_e2_cur",    64'(bus4.sel_cur),   64'd2);
        chk("sw2_e2_done",   64'(bus4.sel_done),  64'd1);
        chk("sw2_e2_ready",  64'(bus4.sel_ready), 64'd1);
        chk("sw2_e2_busy",   64'(bus4.busy),      64'd0);
        tick();
        chk("sw2_e3_done",   64'(bus4.sel_done),  64'd0);
        chk("sw2_e3_muxout", 64'(bus4.muxout),    64'hCC);

        // Request for the already-active channel
        bus4.sel_valid = 1'b1;
        bus4.sel_in    = 2'd2;
        tick();
        bus4.sel_valid = 1'b0;
        chk("same_done",   64'(bus4.sel_done), 64'd1);
        chk("same_err",    64'(bus4.sel_err),  64'd0);
        chk("same_busy",   64'(bus4.busy),     64'd0);
        chk("same_muxout", 64'(bus4.muxout),   64'hCC);
        bus4.muxin[23:16] = 8'h3C;
        tick();
        chk("same_done_clr", 64'(bus4.sel_done), 64'd0);
        chk("same_track",    64'(bus4.muxout),   64'h3C);
        chk("same_busy2",    64'(bus4.busy),     64'd0);
        bus4.muxin[23:16] = 8'hCC;

        // Reset in the middle of a blank window
        bus4.sel_valid = 1'b1;
        bus4.sel_in    = 2'd1;
        tick();
        bus4.sel_valid = 1'b0;
        chk("abort_busy", 64'(bus4.busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_done",   64'(bus4.sel_done),  64'd0);
        chk("abort_cur",    64'(bus4.sel_cur),   64'd0);
        chk("abort_muxout", 64'(bus4.muxout),    64'h00);
        chk("abort_ready",  64'(bus4.sel_ready), 64'd1);
        tick();
        chk("abort_rel_muxout", 64'(bus4.muxout),   64'hAA);
        chk("abort_rel_done",   64'(bus4.sel_done), 64'd0);
        bus4.sel_valid = 1'b1;
        bus4.sel_in    = 2'd3;
        tick();
        bus4.sel_valid = 1'b0;
        chk("abort_new_busy", 64'(bus4.busy), 64'd1);
        tick();
        tick();
        chk("abort_new_muxout", 64'(bus4.muxout),   64'hDD);
        chk("abort_new_cur",    64'(bus4.sel_cur),  64'd3);
        chk("abort_new_done",   64'(bus4.sel_done), 64'd1);

        // sel_valid held high while sel_in changes during blanking
        bus4.sel_valid = 1'b1;
        bus4.sel_in    = 2'd0;
        tick();
        chk("hold_e0_busy", 64'(bus4.busy), 64'd1);
        bus4.sel_in = 2'd1;
        tick();
        chk("hold_e1_muxout", 64'(bus4.muxout), 64'h00);
        bus4.sel_in = 2'd2;
        tick();
        chk("hold_e2_cur",    64'(bus4.sel_cur),  64'd0);
        chk("hold_e2_muxout", 64'(bus4.muxout),   64'hAA);
        chk("hold_e2_done",   64'(bus4.sel_done), 64'd1);
        tick();
        bus4.sel_valid = 1'b0;
        chk("hold_e3_busy",   64'(bus4.busy),     64'd1);
        chk("hold_e3_cur",    64'(bus4.sel_cur),  64'd0);
        chk("hold_e3_done",   64'(bus4.sel_done), 64'd0);
        chk("hold_e3_muxout", 64'(bus4.muxout),   64'h00);
        tick();
        tick();
        chk("hold_e5_cur",    64'(bus4.sel_cur),  64'd2);
        chk("hold_e5_muxout", 64'(bus4.muxout),   64'hCC);
        chk("hold_e5_done",   64'(bus4.sel_done), 64'd1);

        // Reset wins over a simultaneous request
        reset = 1'b1;
        bus4.sel_valid = 1'b1;
        bus4.sel_in    = 2'd1;
        tick();
        bus4.sel_valid = 1'b0;
        reset = 1'b0;
        chk("rstpri_busy", 64'(bus4.busy),    64'd0);
        chk("rstpri_cur",  64'(bus4.sel_cur), 64'd0);
        tick();
        chk("rstpri_muxout", 64'(bus4.muxout), 64'hAA);
        chk("dut5_muxout",   64'(bus5.muxout), 64'hAA);

        // Out-of-range requests on the five-channel instance
        bus5.sel_valid = 1'b1;
        bus5.sel_in    = 3'd5;
        tick();
        bus5.sel_valid = 1'b0;
        chk("err5_err",    64'(bus5.sel_err),   64'd1);
        chk("err5_done",   64'(bus5.sel_done),  64'd0);
        chk("err5_busy",   64'(bus5.busy),      64'd0);
        chk("err5_cur",    64'(bus5.sel_cur),   64'd0);
        chk("err5_muxout", 64'(bus5.muxout),    64'hAA);
        bus5.muxin[7:0] = 8'h11;
        tick();
        chk("err5_clr",   64'(bus5.sel_err), 64'd0);
        chk("err5_track", 64'(bus5.muxout),  64'h11);
        bus5.sel_valid = 1'b1;
        bus5.sel_in    = 3'd7;
        tick();
        bus5.sel_valid = 1'b0;
        chk("err7_err", 64'(bus5.sel_err), 64'd1);
        chk("err7_cur", 64'(bus5.sel_cur), 64'd0);

        // Highest legal index on the five-channel instance
        bus5.sel_valid = 1'b1;
        bus5.sel_in    = 3'd4;
        tick();
        bus5.sel_valid = 1'b0;
        chk("max5_busy", 64'(bus5.busy),    64'd1);
        chk("max5_err",  64'(bus5.sel_err), 64'd0);
        tick();
        tick();
        chk("max5_muxout", 64'(bus5.muxout),   64'hEE);
        chk("max5_cur",    64'(bus5.sel_cur),  64'd4);
        chk("max5_done",   64'(bus5.sel_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

`default_nettype wire
